// File: rtl/programmable_frequency_divisor.sv
// Runtime-programmable clock divider: square-wave enable clock plus tick,
// with continuous / one-shot modes, pause via enable, and abort via load.
module programmable_frequency_divisor #(
   parameter int               WIDTH       = 26,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(25000000)
) (
   input  logic             clk50,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] div_value,
   input  logic             mode,
   input  logic             start,
   output logic             clk,
   output logic             tick,
   output logic             busy,
   output logic             done,
   output logic             load_err,
   output logic [WIDTH-1:0] div_active
);

   logic [WIDTH-1:0] r_counter;
   logic [WIDTH-1:0] r_div_active;
   logic             r_clk;
   logic             r_tick;
   logic             r_busy;
   logic             r_done;
   logic             r_load_err;

   logic             w_load_ok;
   logic             w_load_bad;
   logic             w_start_ok;
   logic             w_count;
   logic             w_wrap;
   logic [WIDTH-1:0] w_div_m1;

   // A zero load is rejected but still outranks start, so start is dropped.
   assign w_load_ok  = load && (div_value != '0);
   assign w_load_bad = load && (div_value == '0);
   assign w_start_ok = start && mode && !r_busy && !load;
   assign w_count    = enable && (r_busy || !mode);
   assign w_div_m1   = r_div_active - {{(WIDTH-1){1'b0}}, 1'b1};
   assign w_wrap     = (r_counter == w_div_m1);

   always_ff @(posedge clk50) begin
      if (reset) begin
         r_counter    <= '0;
         r_div_active <= DEFAULT_DIV;
         r_clk        <= 1'b0;
         r_tick       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_load_err   <= 1'b0;
      end else begin
         r_tick     <= 1'b0;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
         if (w_load_ok) begin
            r_div_active <= div_value;
            r_counter    <= '0;
            r_clk        <= 1'b0;
            r_busy       <= 1'b0;
         end else begin
            if (w_load_bad)
               r_load_err <= 1'b1;
            if (w_start_ok) begin
               r_counter <= '0;
               r_clk     <= 1'b0;
               r_busy    <= 1'b1;
            end else if (w_count) begin
               if (!w_wrap) begin
                  r_counter <= r_counter + {{(WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  r_counter <= '0;
                  r_clk     <= !r_clk;
                  // Rising half of the wave emits tick; falling half ends a one-shot.
                  if (!r_clk)
                     r_tick <= 1'b1;
                  else if (r_busy) begin
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign clk        = r_clk;
   assign tick       = r_tick;
   assign busy       = r_busy;
   assign done       = r_done;
   assign load_err   = r_load_err;
   assign div_active = r_div_active;

endmodule

// File: doc/programmable_frequency_divisor.md
# programmable_frequency_divisor

Runtime-programmable clock divider that generates a square-wave enable clock and a single-cycle tick from the 50 MHz board clock. It has continuous and one-shot modes, pause and abort. It replaces the fixed-ratio divider as the timing source for the elevator controller: floor-travel timers, door timers and the display refresh. The divide ratio is reloadable at run time without a rebuild.

## Interface
- `WIDTH`, default 26: width of the divide register and counter.
- `DEFAULT_DIV`, default 25000000: half-period in `clk50` cycles after reset (1 Hz output from 50 MHz). Must be between 1 and 2^WIDTH-1.
- `clk50`  in  1: system clock. All logic runs on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: count enable. When low, the counter and `clk` hold (pause).
- `load`  in  1: one-cycle strobe that loads `div_value`.
- `div_value`  in  WIDTH: new half-period in cycles, sampled when `load` is high.
- `mode`  in  1: 0 = continuous, 1 = one-shot.
- `start`  in  1: one-cycle strobe that starts a one-shot period.
- `clk`  out  1: divided square wave, registered.
- `tick`  out  1: one-cycle pulse on the cycle after each `clk` 0->1 transition.
- `busy`  out  1: a one-shot period is in progress.
- `done`  out  1: one-cycle pulse when a one-shot period completes.
- `load_err`  out  1: one-cycle pulse when a load of 0 is rejected.
- `div_active`  out  WIDTH: the half-period currently in use.

## Operation
- **Reset.** `counter`=0, `clk`=0, `tick`=0, `busy`=0, `done`=0, `load_err`=0, `div_active`=DEFAULT_DIV.
- **Priority per edge.** `reset` > `load` > `start` > counting.
- **Load with `div_value` != 0.**
  - `div_active` <= `div_value`.
  - `counter`, `clk` and `busy` all go to 0.
  - `tick` and `done` go to 0, so an in-progress one-shot aborts with no `done`.
- **Load with `div_value` == 0.**
  - `div_active` is unchanged and `load_err` pulses for one cycle.
  - Counter, `clk` and `busy` are not disturbed.
- **Start.** Accepted only when `mode`=1 and `busy`=0. Sets `counter`=0, `clk`=0, `busy`=1. Ignored otherwise, with no error.
- **Counting condition.** `enable` && (`busy` || `mode`=0).
- **When counting:**
  - If `counter` != `div_active`-1: `counter` increments.
  - Otherwise (wrap): `counter` <= 0 and `clk` toggles.
  - If `clk` was 0 at the wrap, `tick` <= 1.
  - If `clk` was 1 at the wrap and `busy`=1: `busy` <= 0 and `done` <= 1.
- **When not counting:** `counter` and `clk` hold, and `tick`/`done` are 0.
- **Mode changes.**
  - A one-shot already in progress runs to completion even if `mode` drops to 0.
  - Continuous operation then resumes from `clk`=0, `counter`=0.
  - Raising `mode` to 1 while continuous freezes `clk` at its current level until `start` or `load`.
- **Arithmetic.** `counter` is WIDTH bits, unsigned. The comparison is against `div_active`-1. Because `div_active` is never 0, `counter` never wraps through 2^WIDTH.

## Timing
- **Continuous, half-period N.** `clk` toggles on every N-th enabled edge, giving a period of 2N enabled cycles and a 50 % duty cycle.
  - N=1 makes `clk` toggle every enabled edge.
- **First edge after load or reset.** The first 0->1 of `clk` occurs at the N-th enabled edge. `tick` is high during exactly that following cycle, aligned with `clk` high.
- **One-shot.** `clk` is high for cycles N+1..2N after `start`, counting enabled cycles only.
  - `busy` is high from the cycle after `start` through the 2N-th enabled edge.
  - `done` is high for the one cycle in which `busy` first reads 0.
- **Pause.** Deasserting `enable` stretches the current phase by exactly the number of disabled cycles; no edge is lost or duplicated.
- **Load latency.** The new ratio takes effect on the cycle after `load`; `div_active` updates on that same edge.
- **Simultaneous strobes.** `load` and `start` together: load wins and start is dropped. `reset` with anything: reset wins.

## Test plan
- Reset, then `enable`=1, `mode`=0 with DEFAULT_DIV=4:
  - `clk` rises after the 4th edge and the period is 8 cycles.
  - `tick` gives one 1-cycle pulse per period, coincident with `clk` rising.
  - No `done` pulse.
- Load 3 with `enable`=1, `mode`=0 mid-run while `clk`=1 and `counter`=2:
  - `clk` goes to 0 the next cycle and `div_active`=3.
  - `clk` rises 3 cycles later; period 6.
- Load 0, then `div_value`=0 with `load` pulsed:
  - `load_err` is a 1-cycle pulse.
  - `div_active`, `clk` phase and `counter` sequence are unchanged.
- One-shot with N=2 and `mode`=1, pulse `start`:
  - `busy` is high for 4 cycles; `clk` is 0,0,1,1 during them.
  - `tick` is high once and `done` is high once, right after `busy` falls.
  - A second `start` while `busy` is ignored.
- Continuous with N=4, `enable` dropped for 5 cycles during the high phase:
  - The high phase lasts 4+5=9 cycles and `tick` count is unchanged.
- During a one-shot with N=8, assert `reset` at cycle 5:
  - All outputs return to reset values the next cycle and `div_active`=DEFAULT_DIV.
  - No `done` pulse.
